phase_sequencer: RTL

//   Generates the 3-bit phase that drives the control decoder of the multi-cycle CPU.

---
 rtl/phase_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - instruction phase sequencer for the multi-cycle CPU
// Phase 0 is idle (all decoder enables off); phases 1..5 are fetch, decode,
// execute, memory and write-back. A debounced exec button starts the machine,
// step_mode stops after every instruction and the decoder's hlt freezes it
// until reset. A retired-instruction counter is kept for the display.
module phase_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exec_btn,
  input  logic                 step_mode,
  input  logic                 hlt,
  output logic [2:0]           phase,
  output logic                 running,
  output logic                 halted,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  logic [1:0]      sync_q;
  logic            deb_level;
  logic            deb_level_d;
  logic [DB_W-1:0] db_cnt;
  logic            exec_pulse;
  logic            stop_req;
  logic            stop_now;
  logic            hlt_taken;
  state_t          state;

  // Two-flop synchronizer for the asynchronous push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], exec_btn};
    end
  end

  // Debouncer: accept a new level only after it has been stable for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_level <= 1'b0;
      db_cnt    <= '0;
    end else if (sync_q[1] != deb_level) begin
      if (db_cnt == DB_LAST) begin
        deb_level <= sync_q[1];
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_level_d <= 1'b0;
    end else begin
      deb_level_d <= deb_level;
    end
  end

  assign exec_pulse = deb_level & ~deb_level_d;

  // hlt is only meaningful once the IR has been loaded (phase 2 onwards);
  // a press landing exactly on the retire edge also stops the machine
  assign hlt_taken = hlt && (phase >= 3'd2) && (phase <= 3'd5);
  assign stop_now  = step_mode | stop_req | exec_pulse;

  // Sequencer FSM with registered phase/status outputs and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= 3'd0;
      running     <= 1'b0;
      halted      <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= '0;
      stop_req    <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          stop_req <= 1'b0;
          halted   <= 1'b0;
          if (exec_pulse) begin
            state   <= S_RUN;
            phase   <= 3'd1;
            running <= 1'b1;
          end else begin
            phase   <= 3'd0;
            running <= 1'b0;
          end
        end

        S_RUN: begin
          if (phase == 3'd0 || phase > 3'd5) begin
            // corrupted phase while running: fall back to idle
            state    <= S_IDLE;
            phase    <= 3'd0;
            running  <= 1'b0;
            halted   <= 1'b0;
            stop_req <= 1'b0;
          end else if (hlt_taken) begin
            state       <= S_HALT;
            phase       <= 3'd0;
            running     <= 1'b0;
            halted      <= 1'b1;
            instr_done  <= 1'b1;
            instr_count <= instr_count + CNT_WIDTH'(1);
            stop_req    <= 1'b0;
          end else if (phase == 3'd5) begin
            instr_done  <= 1'b1;
            instr_count <= instr_count + CNT_WIDTH'(1);
            stop_req    <= 1'b0;
            if (stop_now) begin
              state   <= S_IDLE;
              phase   <= 3'd0;
              running <= 1'b0;
            end else begin
              phase <= 3'd1;
            end
          end else begin
            phase <= phase + 3'd1;
            if (exec_pulse) begin
              stop_req <= 1'b1;
            end
          end
        end

        S_HALT: begin
          phase    <= 3'd0;
          running  <= 1'b0;
          halted   <= 1'b1;
          stop_req <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          phase    <= 3'd0;
          running  <= 1'b0;
          halted   <= 1'b0;
          stop_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
